// File: rtl/imem_fetch_responder_if.sv
// Fetch-request, instruction-memory and response signals of the Y86 fetch responder.
// The slave modport is the responder's view; master is the fetch stage plus memory.
interface imem_fetch_responder_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [47:0]       resp_bytes;
  logic [ADDR_W-1:0] resp_pc;

  modport slave (
    input  req_valid, req_pc, mem_rdata, resp_ready,
    output req_ready, mem_rd, mem_addr, resp_valid, resp_bytes, resp_pc
  );

  modport master (
    output req_valid, req_pc, mem_rdata, resp_ready,
    input  req_ready, mem_rd, mem_addr, resp_valid, resp_bytes, resp_pc
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Gathers the 6 instruction bytes at an arbitrary byte PC from a 32-bit synchronous
// instruction RAM using 2 or 3 aligned reads, and returns them little-endian.
module imem_fetch_responder (
  input  logic                  clk,
  input  logic                  rst,
  imem_fetch_responder_if.slave bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BUF_W  = 3 * WORD_W;
  localparam int unsigned RESP_W = 48;

  typedef enum logic [1:0] {IDLE, READ, LAST, RESP} state_e;

  state_e              state_q;
  logic                req_ready_q;
  logic                mem_rd_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                resp_valid_q;
  logic [RESP_W-1:0]   resp_bytes_q;
  logic [ADDR_W-1:0]   resp_pc_q;
  logic [1:0]          off_q;
  logic [1:0]          issue_idx_q;
  logic [1:0]          last_idx_q;
  logic [1:0]          cap_idx_q;
  logic                pend_q;
  logic [BUF_W-1:0]    buf_q;
  logic [BUF_W-1:0]    buf_d;
  logic [RESP_W-1:0]   resp_bytes_d;

  // Buffer with the word arriving this cycle merged in, so LAST can build the response directly
  always_comb begin
    buf_d = buf_q;
    if (pend_q) begin
      case (cap_idx_q)
        2'd0:    buf_d[31:0]  = bus.mem_rdata;
        2'd1:    buf_d[63:32] = bus.mem_rdata;
        2'd2:    buf_d[95:64] = bus.mem_rdata;
        default: ;
      endcase
    end
    resp_bytes_d = buf_d[7'({off_q, 3'b000}) +: RESP_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_bytes_q <= '0;
      resp_pc_q    <= '0;
      off_q        <= '0;
      issue_idx_q  <= '0;
      last_idx_q   <= '0;
      cap_idx_q    <= '0;
      pend_q       <= 1'b0;
      buf_q        <= '0;
    end else begin
      // Read data lands one cycle after each strobe; reset drops any pending word
      pend_q <= mem_rd_q;
      if (pend_q) begin
        buf_q     <= buf_d;
        cap_idx_q <= cap_idx_q + 2'd1;
      end

      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            state_q     <= READ;
            req_ready_q <= 1'b0;
            resp_pc_q   <= bus.req_pc;
            off_q       <= bus.req_pc[1:0];
            last_idx_q  <= (bus.req_pc[1:0] == 2'd3) ? 2'd2 : 2'd1;
            issue_idx_q <= 2'd0;
            cap_idx_q   <= 2'd0;
            mem_rd_q    <= 1'b1;
            mem_addr_q  <= {bus.req_pc[ADDR_W-1:2], 2'b00};
          end
        end
        READ: begin
          if (issue_idx_q == last_idx_q) begin
            state_q  <= LAST;
            mem_rd_q <= 1'b0;
          end else begin
            issue_idx_q <= issue_idx_q + 2'd1;
            mem_addr_q  <= mem_addr_q + ADDR_W'(4);
          end
        end
        LAST: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_bytes_q <= resp_bytes_d;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_bytes = resp_bytes_q;
  assign bus.resp_pc    = resp_pc_q;

endmodule
